// File: rtl/stdout_uart_pkg.sv
// Shared constants for the stdout console UART: register offsets, STATUS
// bit layout and transmit FSM state encoding.
package stdout_uart_pkg;

    localparam logic [2:0] REG_DATA   = 3'd0;
    localparam logic [2:0] REG_STATUS = 3'd4;

    localparam int COUNT_LSB = 0;
    localparam int FULL      = 4;
    localparam int TX_ACTIVE = 5;
    localparam int OVERFLOW  = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/uart_byte_fifo.sv
// Byte FIFO feeding the console transmitter. Head byte is visible on pop_data
// while the FIFO is non-empty; pushes to a full FIFO are ignored.
module uart_byte_fifo #(
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [7:0]    push_data,
    input  logic          pop,
    output logic [7:0]    pop_data,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok;
    logic          pop_ok;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    // Full is judged on pre-edge state, so a same-cycle pop never frees room.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/stdout_uart_tx.sv
// Memory-mapped console output: DATA stores are queued and sent as UART 8N1,
// STATUS exposes fill level, activity and a sticky overflow flag.
module stdout_uart_tx
    import stdout_uart_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        mem_write,
    input  logic        mem_read,
    output logic        hit,
    output logic [31:0] rdata,
    output logic        txd,
    output logic        busy
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    tx_state_t     state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          txd_q, txd_d;
    logic          overflow_q, overflow_d;

    logic          sel_status;
    logic          wr_data;
    logic          wr_status;
    logic          pop;
    logic          baud_end;
    logic          tx_active;
    logic [31:0]   status;

    logic [7:0]    fifo_rdata;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [4:0]    count_ext;

    logic          unused_ok;
    assign unused_ok = ^{addr[1:0], wdata[31:8]};

    assign hit        = (addr[31:3] == BASE_ADDR[31:3]);
    assign sel_status = (addr[2] == REG_STATUS[2]);
    assign wr_data    = mem_write && hit && !sel_status;
    assign wr_status  = mem_write && hit && sel_status;

    uart_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (wr_data),
        .push_data (wdata[7:0]),
        .pop       (pop),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign count_ext = 5'(fifo_count);
    assign tx_active = (state_q != IDLE);
    assign busy      = tx_active || !fifo_empty;

    always_comb begin
        status                     = '0;
        status[COUNT_LSB +: 4]     = count_ext[3:0];
        status[FULL]               = fifo_full;
        status[TX_ACTIVE]          = tx_active;
        status[OVERFLOW]           = overflow_q;
    end

    // DATA reads as zero, so only a STATUS hit drives the bus.
    assign rdata = (mem_read && hit && sel_status) ? status : 32'd0;

    always_comb begin
        overflow_d = overflow_q;
        if (wr_status) begin
            overflow_d = 1'b0;
        end else if (wr_data && fifo_full) begin
            overflow_d = 1'b1;
        end
    end

    assign baud_end = (baud_q == BW'(CLKS_PER_BIT - 1));

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_rdata;
                    state_d = START;
                    baud_d  = '0;
                end
            end
            START: begin
                if (baud_end) begin
                    state_d   = DATA;
                    baud_d    = '0;
                    bit_idx_d = '0;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d    = '0;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    // Chain straight into the next start bit so frames have no gap.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_rdata;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                baud_d  = '0;
            end
        endcase

        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[bit_idx_d];
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            txd_q      <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            txd_q      <= txd_d;
            overflow_q <= overflow_d;
        end
    end

    assign txd = txd_q;

endmodule

// File: tb/tb_stdout_uart_tx.sv
// Directed bench for stdout_uart_tx: bus stores/loads drive a byte scoreboard
// that a txd frame decoder drains and compares.
module tb_stdout_uart_tx;

    localparam int          CPB  = 4;
    localparam logic [31:0] BASE = 32'hFFFF_0000;

    logic        clk;
    logic        rst_n;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_write;
    logic        mem_read;
    logic        hit;
    logic [31:0] rdata;
    logic        txd;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] exp_q[$];
    int         start_cyc[$];

    stdout_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (8),
        .BASE_ADDR    (BASE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .addr      (addr),
        .wdata     (wdata),
        .mem_write (mem_write),
        .mem_read  (mem_read),
        .hit       (hit),
        .rdata     (rdata),
        .txd       (txd),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        addr      = a;
        wdata     = d;
        mem_write = 1'b1;
        @(posedge clk);
        #1;
        mem_write = 1'b0;
        addr      = '0;
        wdata     = '0;
    endtask

    task automatic load(input logic [31:0] a, output logic [31:0] d, output logic h);
        addr     = a;
        mem_read = 1'b1;
        #1;
        d        = rdata;
        h        = hit;
        mem_read = 1'b0;
        addr     = '0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        check("idle_within_budget", {31'd0, busy}, 32'd0);
    endtask

    task automatic mon_wait(input int n, inout logic ab);
        repeat (n) begin
            @(negedge clk);
            if (!rst_n) ab = 1'b1;
        end
    endtask

    // Frame decoder: samples each bit mid-period and pops the scoreboard.
    initial begin : monitor
        logic       prev;
        logic       ab;
        logic [7:0] b;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev = 1'b1;
            end else if (prev && !txd) begin
                start_cyc.push_back(cyc);
                ab = 1'b0;
                b  = '0;
                mon_wait(CPB / 2, ab);
                if (!ab) check("start_bit", {31'd0, txd}, 32'd0);
                for (int i = 0; i < 8; i++) begin
                    if (!ab) begin
                        mon_wait(CPB, ab);
                        b[i] = txd;
                    end
                end
                if (!ab) mon_wait(CPB, ab);
                if (!ab) begin
                    check("stop_bit", {31'd0, txd}, 32'd1);
                    checks++;
                    assert (exp_q.size() > 0) else begin
                        errors++;
                        $error("FAIL frame_expected: observed byte 0x%0h expected no frame", b);
                    end
                    if (exp_q.size() > 0) check("frame_byte", {24'd0, b}, {24'd0, exp_q.pop_front()});
                end
                prev = txd;
            end else begin
                prev = txd;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [31:0] d;
        logic        h;
        int          k;
        int          lows;

        rst_n     = 1'b0;
        addr      = '0;
        wdata     = '0;
        mem_write = 1'b0;
        mem_read  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state.
        check("rst_txd", {31'd0, txd}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        load(BASE + 32'd4, d, h);
        check("rst_status", d, 32'h0);
        check("rst_hit", {31'd0, h}, 32'd1);
        tick();

        // Single byte 0x41, frame timing.
        start_cyc.delete();
        exp_q.push_back(8'h41);
        store(BASE, 32'h41);
        k = cyc;
        load(BASE + 32'd4, d, h);
        check("one_status_queued", d, 32'h01);
        tick();
        check("one_txd_start", {31'd0, txd}, 32'd0);
        load(BASE + 32'd4, d, h);
        check("one_status_active", d, 32'h20);
        wait_idle(100);
        check("one_frame_len", cyc - k, 32'd41);
        check("one_txd_idle", {31'd0, txd}, 32'd1);

        // Back-to-back 0x55, 0xAA.
        tick();
        start_cyc.delete();
        exp_q.push_back(8'h55);
        exp_q.push_back(8'hAA);
        store(BASE, 32'h55);
        k = cyc;
        store(BASE, 32'hAA);
        load(BASE + 32'd4, d, h);
        check("b2b_status", d, 32'h21);
        wait_idle(200);
        check("b2b_total_len", cyc - k, 32'd81);
        check("b2b_frames", start_cyc.size(), 32'd2);
        if (start_cyc.size() == 2) check("b2b_no_gap", start_cyc[1] - start_cyc[0], 32'd40);

        // Overflow: one in flight, then nine stores into an empty FIFO.
        tick();
        exp_q.push_back(8'h30);
        store(BASE, 32'h30);
        tick();
        for (int i = 0; i < 9; i++) begin
            if (i < 8) exp_q.push_back(8'h61 + 8'(i));
            store(BASE, 32'h61 + i);
        end
        load(BASE + 32'd4, d, h);
        check("ovf_status", d, 32'h78);
        check("ovf_busy", {31'd0, busy}, 32'd1);
        addr      = BASE + 32'd4;
        wdata     = 32'hFFFF_FFFF;
        mem_read  = 1'b1;
        mem_write = 1'b1;
        #1;
        check("ovf_rw_pre_edge", rdata, 32'h78);
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        load(BASE + 32'd4, d, h);
        check("ovf_cleared", d, 32'h38);
        load(BASE, d, h);
        check("data_read_zero", d, 32'h0);
        tick();
        load(BASE + 32'd8, d, h);
        check("miss_hit", {31'd0, h}, 32'd0);
        check("miss_rdata", d, 32'h0);
        store(BASE + 32'd8, 32'h7E);
        load(BASE + 32'd4, d, h);
        check("miss_store_no_effect", d, 32'h38);
        wait_idle(600);
        check("ovf_drained", exp_q.size(), 32'd0);

        // Reset during data bit 3 of 0xA5 with a second byte queued.
        tick();
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h3C);
        store(BASE, 32'hA5);
        k = cyc;
        store(BASE, 32'h3C);
        while (cyc < k + 18) tick();
        check("rst_mid_bit3_low", {31'd0, txd}, 32'd0);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_async_txd", {31'd0, txd}, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        start_cyc.delete();
        load(BASE + 32'd4, d, h);
        check("rst_mid_status", d, 32'h0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        lows = 0;
        repeat (100) begin
            tick();
            if (!txd) lows++;
        end
        check("rst_mid_quiet", lows, 32'd0);
        check("rst_mid_no_frames", start_cyc.size(), 32'd0);

        // Push on the exact cycle STOP ends with one byte already queued.
        start_cyc.delete();
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h33);
        store(BASE, 32'h11);
        k = cyc;
        tick();
        store(BASE, 32'h22);
        while (cyc < k + 40) tick();
        check("edge_stop_txd", {31'd0, txd}, 32'd1);
        load(BASE + 32'd4, d, h);
        check("edge_pre_status", d, 32'h21);
        store(BASE, 32'h33);
        load(BASE + 32'd4, d, h);
        check("edge_post_status", d, 32'h21);
        check("edge_next_start", {31'd0, txd}, 32'd0);
        wait_idle(300);
        check("edge_frames", start_cyc.size(), 32'd3);
        if (start_cyc.size() == 3) begin
            check("edge_gap_1", start_cyc[1] - start_cyc[0], 32'd40);
            check("edge_gap_2", start_cyc[2] - start_cyc[1], 32'd40);
        end
        check("edge_drained", exp_q.size(), 32'd0);

        repeat (5) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
